// File: rtl/cpu_multiply_iterative.sv
// Iterative shift-and-add multiplier: BITS_PER_CYCLE multiplier bits per BUSY cycle,
// magnitudes multiplied unsigned and the sign applied on the final write.
//
//   state | meaning
//   IDLE  | waiting for i_latch; operands, mode and sign captured on the request edge
//   BUSY  | accumulating partial products, WIDTH/BITS_PER_CYCLE edges
//   DONE  | o_ready high until i_latch drops (a zero operand lands here straight from IDLE)
module cpu_multiply_iterative #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_latch,
    input  logic [1:0]           i_mode,
    input  logic [WIDTH-1:0]     i_op1,
    input  logic [WIDTH-1:0]     i_op2,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic [2*WIDTH-1:0]   o_result
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [PW-1:0]      result_q, result_d;

    logic               op1_signed, op2_signed;
    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [PW-1:0]      step;
    logic [PW-1:0]      acc_sum;
    logic               last_step;

    always_comb begin
        op1_signed = (i_mode == 2'b01) || (i_mode == 2'b10);
        op2_signed = (i_mode == 2'b01);
        op1_neg    = op1_signed & i_op1[WIDTH-1];
        op2_neg    = op2_signed & i_op2[WIDTH-1];
        // The most-negative value negates to itself, which is its correct unsigned magnitude.
        op1_mag    = op1_neg ? (~i_op1 + WIDTH'(1)) : i_op1;
        op2_mag    = op2_neg ? (~i_op2 + WIDTH'(1)) : i_op2;

        step = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (mplier_q[b]) begin
                step = step + (mcand_q << b);
            end
        end
        acc_sum   = acc_q + step;
        last_step = (cnt_q == CNT_W'(N - 1));
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                if (i_latch) begin
                    mcand_d  = PW'(op1_mag);
                    mplier_d = op2_mag;
                    neg_d    = op1_neg ^ op2_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ((i_op1 == '0) || (i_op2 == '0)) ? DONE : BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d  = DONE;
                    ready_d  = 1'b1;
                    result_d = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
                end
            end
            DONE: begin
                // Only the zero shortcut arrives here with ready low; raise it one edge later.
                if (!ready_q) begin
                    ready_d  = 1'b1;
                    result_d = '0;
                end else if (!i_latch) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase

        busy_d = (state_d == BUSY);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_busy   = busy_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_cpu_multiply_iterative.sv
// Bench for cpu_multiply_iterative: directed vectors feed a scoreboard queue,
// a negedge monitor pops and checks result and latency on each o_ready rise.
module tb_cpu_multiply_iterative;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  mode;
    logic [31:0] op1, op2;
    logic        latch  [3];
    logic        ready  [3];
    logic        busy   [3];
    logic [63:0] result [3];

    cpu_multiply_iterative #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .i_clock(clk), .i_reset_n(rst_n), .i_latch(latch[0]), .i_mode(mode),
        .i_op1(op1), .i_op2(op2), .o_ready(ready[0]), .o_busy(busy[0]), .o_result(result[0]));
    cpu_multiply_iterative #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_latch(latch[1]), .i_mode(mode),
        .i_op1(op1), .i_op2(op2), .o_ready(ready[1]), .o_busy(busy[1]), .o_result(result[1]));
    cpu_multiply_iterative #(.WIDTH(32), .BITS_PER_CYCLE(8)) u_dut8 (
        .i_clock(clk), .i_reset_n(rst_n), .i_latch(latch[2]), .i_mode(mode),
        .i_op1(op1), .i_op2(op2), .o_ready(ready[2]), .o_busy(busy[2]), .o_result(result[2]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          dut;
        logic [63:0] res;
        int          lat;
        int          cap;
        string       name;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic rdy_prev [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            chk("ready_busy_exclusive", 64'(ready[k] & busy[k]), 64'(0));
            if (ready[k] === 1'b1 && rdy_prev[k] !== 1'b1) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: dut %0d raised o_ready with result 0x%0h, none expected", k, result[k]);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_dut"}, 64'(k), 64'(e.dut));
                    chk({e.name, "_result"}, result[k], e.res);
                    chk({e.name, "_latency"}, 64'(cyc - e.cap), 64'(e.lat));
                end
            end
            rdy_prev[k] = ready[k];
        end
    end

    task automatic run(input int k, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input int lat, input string name,
                       input int drop_at, input bit no_busy);
        int   waited;
        bit   got;
        bit   saw_busy;
        exp_t e;
        @(negedge clk);
        mode     = m;
        op1      = a;
        op2      = b;
        latch[k] = 1'b1;
        e.dut = k; e.res = exp_res; e.lat = lat; e.cap = cyc + 1; e.name = name;
        sbq.push_back(e);
        @(negedge clk);
        mode = ~m;
        op1  = ~a ^ 32'h5a5a_0f0f;
        op2  = b + 32'd3;
        waited   = 1;
        got      = 1'b0;
        saw_busy = (busy[k] === 1'b1);
        while (!got && waited < 200) begin
            if (drop_at > 0 && waited == drop_at) latch[k] = 1'b0;
            if (ready[k] === 1'b1) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                waited++;
                if (busy[k] === 1'b1) saw_busy = 1'b1;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: o_ready not seen after %0d cycles, required after %0d", name, waited, lat);
        end
        if (no_busy) chk({name, "_busy_never"}, 64'(saw_busy), 64'(0));
        if (drop_at > 0) begin
            @(negedge clk);
            chk({name, "_pulse_ready"}, 64'(ready[k]), 64'(0));
            chk({name, "_pulse_busy"}, 64'(busy[k]), 64'(0));
        end else begin
            @(negedge clk);
            chk({name, "_hold_ready"}, 64'(ready[k]), 64'(1));
            chk({name, "_hold_result"}, result[k], exp_res);
            latch[k] = 1'b0;
            @(negedge clk);
            chk({name, "_drop_ready"}, 64'(ready[k]), 64'(0));
            chk({name, "_idle_result"}, result[k], exp_res);
        end
        latch[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mode  = 2'b00;
        op1   = '0;
        op2   = '0;
        for (int k = 0; k < 3; k++) latch[k] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", 64'(ready[k]), 64'(0));
            chk("reset_busy", 64'(busy[k]), 64'(0));
            chk("reset_result", result[k], 64'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 64'(busy[0]), 64'(0));

        run(0, 2'b00, 32'd111, 32'd222, 64'd24642, 8, "u_111x222", 0, 1'b0);
        run(0, 2'b00, 32'd555, 32'd666, 64'd369630, 8, "u_555x666", 0, 1'b0);
        run(0, 2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 8, "s_m3x7", 0, 1'b0);
        run(0, 2'b01, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 8, "s_7xm3", 0, 1'b0);
        run(0, 2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'd30, 8, "s_m5xm6", 0, 1'b0);
        run(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 8, "s_minxmin", 0, 1'b0);
        run(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 8, "su_allones", 0, 1'b0);
        run(0, 2'b10, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 64'hFFFF_FFFD_0000_0003, 8, "su_m3xmax", 0, 1'b0);
        run(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8, "u_allones", 0, 1'b0);
        run(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8, "m11_allones", 0, 1'b0);
        run(0, 2'b00, 32'd0, 32'd12345, 64'd0, 1, "zero_op1", 0, 1'b1);
        run(0, 2'b01, 32'hFFFF_FFFD, 32'd0, 64'd0, 1, "zero_op2", 0, 1'b1);
        run(0, 2'b00, 32'd1234, 32'd5678, 64'd7006652, 8, "early_drop", 3, 1'b0);

        @(negedge clk);
        mode     = 2'b00;
        op1      = 32'd1000;
        op2      = 32'd1000;
        latch[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("midbusy_busy", 64'(busy[0]), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ready", 64'(ready[0]), 64'(0));
        chk("async_reset_busy", 64'(busy[0]), 64'(0));
        chk("async_reset_result", result[0], 64'(0));
        latch[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_busy", 64'(busy[0]), 64'(0));
        chk("post_abort_ready", 64'(ready[0]), 64'(0));
        run(0, 2'b00, 32'd6, 32'd7, 64'd42, 8, "after_reset_6x7", 0, 1'b0);

        run(1, 2'b00, 32'd111, 32'd222, 64'd24642, 32, "bpc1_111x222", 0, 1'b0);
        run(2, 2'b00, 32'd111, 32'd222, 64'd24642, 4, "bpc8_111x222", 0, 1'b0);
        run(2, 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4, "bpc8_minxmin", 0, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_multiply_iterative.md
CPU_MULTIPLY_ITERATIVE -- requirements
Module: CPU_Multiply_Iterative

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width; the result is 2*WIDTH bits.
REQ-002 Parameter BITS_PER_CYCLE, default 4, SHALL set the multiplier bits consumed per BUSY cycle. Legal values are 1, 2, 4 and 8, and WIDTH SHALL be divisible by BITS_PER_CYCLE.
REQ-003 i_clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 i_latch  input  1  SHALL be the request; held high by the requester until o_ready is seen.
REQ-006 i_mode  input  2  SHALL select signedness: 00 = unsigned x unsigned, 01 = signed x signed, 10 = signed op1 x unsigned op2, 11 = treated as 00.
REQ-007 i_op1  input  WIDTH  SHALL be the multiplicand.
REQ-008 i_op2  input  WIDTH  SHALL be the multiplier.
REQ-009 o_ready  output  1  SHALL be the registered result-valid flag.
REQ-010 o_busy  output  1  SHALL be high while a computation is in progress (state BUSY).
REQ-011 o_result  output  2*WIDTH  SHALL be the registered full-width product.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 In IDLE, when i_latch=1 at a clock edge, the block SHALL capture i_op1, i_op2 and i_mode.
REQ-014 At that capture edge, the block SHALL load the operand magnitudes and record the result sign = sign(op1) XOR sign(op2), considering only the operands signed under the captured i_mode.
REQ-015 At that capture edge, the block SHALL clear the accumulator and step counter and enter BUSY.
REQ-016 Zero fast path: if either captured operand equals 0, the block SHALL skip BUSY, enter DONE directly with o_result=0, and assert o_ready on the next edge.
REQ-017 In BUSY, each edge SHALL add (multiplicand magnitude x next BITS_PER_CYCLE multiplier bits, LSB first), shifted into position, to the accumulator and increment the counter.
REQ-018 BUSY SHALL last exactly N = WIDTH/BITS_PER_CYCLE edges; on the Nth edge the block SHALL write o_result, enter DONE and set o_ready=1.
REQ-019 The value written to o_result SHALL be the accumulator, two's-complement negated when the recorded sign is negative.
REQ-020 Latency from the capture edge to o_ready high SHALL therefore be N edges (8 for the defaults), or 1 edge on the zero fast path.
REQ-021 Changes to i_op1, i_op2 or i_mode after the capture edge SHALL have no effect on the running computation.
REQ-022 In DONE, o_ready SHALL remain 1 and o_result stable while i_latch=1.
REQ-023 In DONE, the first edge with i_latch=0 SHALL return the block to IDLE and clear o_ready. o_ready is therefore low one edge after the requester drops i_latch.
REQ-024 A request SHALL never restart from DONE without first passing through IDLE; back-to-back requests require i_latch low for at least one edge.
REQ-025 If i_latch falls during BUSY, the computation SHALL still complete, o_ready SHALL pulse for exactly one cycle in DONE, and the state SHALL then return to IDLE.
REQ-026 o_result SHALL hold its last value in IDLE until the next result is written.
REQ-027 Products SHALL be exact for all operand values, including the most-negative signed operand (e.g. -2^31 x -2^31 = 2^62), with no overflow inside 2*WIDTH bits.
REQ-028 o_busy SHALL equal (state == BUSY) as a registered value; o_ready and o_busy SHALL never both be 1.

Reset
REQ-029 While i_reset_n=0, the block SHALL asynchronously force state=IDLE, o_ready=0, o_busy=0, o_result=0, and clear the counter and accumulator.
REQ-030 Reset asserted mid-BUSY or in DONE SHALL abandon the operation; after release the block SHALL accept a new request only on an edge with i_latch=1.
REQ-031 No output SHALL glitch high during or on release of reset.

Verification
REQ-032 The bench SHALL cover the unsigned case: mode 00, op1=111, op2=222 -> o_ready after 8 edges, o_result=24642; drop i_latch -> o_ready=0 after 1 edge. Repeat with 555 x 666 -> 369630.
REQ-033 The bench SHALL cover the signed x signed case: mode 01, op1=-3 (0xFFFFFFFD), op2=7 -> o_result=0xFFFFFFFFFFFFFFEB. Also -2^31 x -2^31 -> 0x4000000000000000.
REQ-034 The bench SHALL cover the signed x unsigned case: mode 10, op1=0xFFFFFFFF, op2=0xFFFFFFFF -> o_result=0xFFFFFFFF00000001. The same operands in mode 00 -> 0xFFFFFFFE00000001.
REQ-035 The bench SHALL cover the zero fast path: op1=0, op2=12345 -> o_ready 1 edge after capture, o_result=0, o_busy never high.
REQ-036 The bench SHALL cover early i_latch drop: drop i_latch at BUSY cycle 3 -> o_ready high exactly 1 cycle at edge 8 with the correct product, then IDLE.
REQ-037 The bench SHALL cover reset mid-BUSY: assert i_reset_n=0 at BUSY cycle 4 -> all outputs 0 immediately. After release, 6 x 7 -> 42 with full latency.
REQ-038 The bench SHALL repeat the 111 x 222 case with BITS_PER_CYCLE=1 -> latency 32 edges, and with BITS_PER_CYCLE=8 -> latency 4 edges.
